// File: rtl/wbu_regfile_pipe.sv
// rtl/wbu_regfile_pipe.sv - pipelined writeback stage with integer register file
// One staging slot commits to rf/pc/instret; combinational reads forward the staged result.
module wbu_regfile_pipe #(
  parameter int          ADDR_WIDTH = 5,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_REGS   = 16,
  parameter int          NUM_RD     = 2,
  parameter logic [31:0] RESET_PC   = 32'h3000_0000,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [31:0]                    in_inst,
  input  logic [DATA_WIDTH-1:0]          in_wdata,
  input  logic [31:0]                    in_next_pc,
  input  logic [63:0]                    in_num,
  input  logic                           commit_en,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rdata,
  output logic [31:0]                    pc,
  output logic                           retire_valid,
  output logic [63:0]                    retire_num,
  output logic [63:0]                    instret,
  output logic                           hz_valid,
  output logic [31:0]                    hz_inst,
  output logic [DATA_WIDTH-1:0]          hz_data
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic                  s_valid_q, s_valid_d;
  logic [31:0]           s_inst_q, s_inst_d;
  logic [DATA_WIDTH-1:0] s_wdata_q, s_wdata_d;
  logic [31:0]           s_next_pc_q, s_next_pc_d;
  logic [63:0]           s_num_q, s_num_d;
  logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] rf_d [NUM_REGS];
  logic [31:0]           pc_q, pc_d;
  logic [63:0]           instret_q, instret_d;
  logic                  retire_valid_q, retire_valid_d;
  logic [63:0]           retire_num_q, retire_num_d;

  logic             accept, commit, s_wen;
  logic [IDX_W-1:0] s_idx;
  logic             unused_raddr_bits;

  assign unused_raddr_bits = ^raddr;

  assign in_ready = !s_valid_q || commit_en;
  assign accept   = in_valid && in_ready;
  assign commit   = s_valid_q && commit_en;
  assign s_idx    = s_inst_q[7 +: IDX_W];

  always_comb begin
    s_wen = 1'b0;
    case (s_inst_q[6:0])
      7'b0010011, 7'b0110111, 7'b0010111, 7'b1110011,
      7'b1101111, 7'b1100111, 7'b0110011, 7'b0000011: s_wen = 1'b1;
      default: s_wen = 1'b0;
    endcase
  end

  always_comb begin
    s_valid_d      = s_valid_q;
    s_inst_d       = s_inst_q;
    s_wdata_d      = s_wdata_q;
    s_next_pc_d    = s_next_pc_q;
    s_num_d        = s_num_q;
    rf_d           = rf_q;
    pc_d           = pc_q;
    instret_d      = instret_q;
    retire_num_d   = retire_num_q;
    retire_valid_d = commit;
    if (commit) begin
      pc_d         = s_next_pc_q;
      instret_d    = instret_q + 64'd1;
      retire_num_d = s_num_q;
      if (s_wen && s_idx != '0) rf_d[s_idx] = s_wdata_q;
    end
    // A same-cycle accept overwrites the slot after its old entry commits.
    if (accept) begin
      s_valid_d   = 1'b1;
      s_inst_d    = in_inst;
      s_wdata_d   = in_wdata;
      s_next_pc_d = in_next_pc;
      s_num_d     = in_num;
    end else if (commit) begin
      s_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_valid_q      <= 1'b0;
      s_inst_q       <= '0;
      s_wdata_q      <= '0;
      s_next_pc_q    <= '0;
      s_num_q        <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
      pc_q           <= RESET_PC;
      instret_q      <= '0;
      retire_valid_q <= 1'b0;
      retire_num_q   <= '0;
    end else begin
      s_valid_q      <= s_valid_d;
      s_inst_q       <= s_inst_d;
      s_wdata_q      <= s_wdata_d;
      s_next_pc_q    <= s_next_pc_d;
      s_num_q        <= s_num_d;
      rf_q           <= rf_d;
      pc_q           <= pc_d;
      instret_q      <= instret_d;
      retire_valid_q <= retire_valid_d;
      retire_num_q   <= retire_num_d;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (raddr[i*ADDR_WIDTH +: IDX_W] == '0) begin
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else if (BYPASS && s_valid_q && s_wen &&
                   s_idx == raddr[i*ADDR_WIDTH +: IDX_W]) begin
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = s_wdata_q;
      end else begin
        rdata[i*DATA_WIDTH +: DATA_WIDTH] = rf_q[raddr[i*ADDR_WIDTH +: IDX_W]];
      end
    end
  end

  assign pc           = pc_q;
  assign instret      = instret_q;
  assign retire_valid = retire_valid_q;
  assign retire_num   = retire_num_q;
  assign hz_valid     = s_valid_q;
  assign hz_inst      = s_inst_q;
  assign hz_data      = s_wdata_q;

endmodule

// File: tb/tb_wbu_regfile_pipe.sv
// tb/tb_wbu_regfile_pipe.sv - bench for wbu_regfile_pipe (RV32E+bypass and RV32I no-bypass instances)
module tb_wbu_regfile_pipe;

  localparam logic [31:0] P = 32'h3000_0000;
  localparam logic [6:0] OP_ADDI = 7'b0010011, OP_LW = 7'b0000011, OP_SW = 7'b0100011;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_wdata = '0;
  logic [31:0] in_next_pc = '0;
  logic [63:0] in_num = '0;
  logic        commit_en = 1'b0;
  logic [9:0]  raddr = '0;

  logic        rdy_a, rv_a, hzv_a, rdy_b, rv_b, hzv_b;
  logic [63:0] rdata_a, rdata_b, rnum_a, rnum_b, ir_a, ir_b;
  logic [31:0] pc_a, pc_b, hzi_a, hzi_b, hzd_a, hzd_b;

  always #5 clock = ~clock;

  wbu_regfile_pipe dut_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a),
    .in_inst(in_inst), .in_wdata(in_wdata), .in_next_pc(in_next_pc), .in_num(in_num),
    .commit_en(commit_en), .raddr(raddr), .rdata(rdata_a), .pc(pc_a),
    .retire_valid(rv_a), .retire_num(rnum_a), .instret(ir_a),
    .hz_valid(hzv_a), .hz_inst(hzi_a), .hz_data(hzd_a)
  );

  wbu_regfile_pipe #(.NUM_REGS(32), .BYPASS(1'b0)) dut_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b),
    .in_inst(in_inst), .in_wdata(in_wdata), .in_next_pc(in_next_pc), .in_num(in_num),
    .commit_en(commit_en), .raddr(raddr), .rdata(rdata_b), .pc(pc_b),
    .retire_valid(rv_b), .retire_num(rnum_b), .instret(ir_b),
    .hz_valid(hzv_b), .hz_inst(hzi_b), .hz_data(hzd_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: architectural state kept as plain variables and arrays.
  logic [6:0]  wen_ops [8] = '{7'h13, 7'h37, 7'h17, 7'h73, 7'h6f, 7'h67, 7'h33, 7'h03};
  bit          m_valid;
  logic [31:0] m_inst, m_wdata, m_npc, m_pc;
  logic [63:0] m_num, m_instret, m_rnum;
  bit          m_rv;
  logic [31:0] m_rf_a [16];
  logic [31:0] m_rf_b [32];

  function automatic bit writes(input logic [31:0] inst);
    foreach (wen_ops[k]) if (inst[6:0] == wen_ops[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input bit cfg_b, input logic [4:0] a);
    int n = cfg_b ? 32 : 16;
    int i = int'(a) % n;
    if (i == 0) return 32'h0;
    if (!cfg_b && m_valid && writes(m_inst) && (int'(m_inst[11:7]) % n) == i) return m_wdata;
    return cfg_b ? m_rf_b[i] : m_rf_a[i];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_inst = '0; m_wdata = '0; m_npc = '0; m_num = '0;
    m_pc = P; m_instret = '0; m_rnum = '0; m_rv = 0;
    foreach (m_rf_a[k]) m_rf_a[k] = '0;
    foreach (m_rf_b[k]) m_rf_b[k] = '0;
  endtask

  task automatic model_edge();
    bit acc, com;
    acc = in_valid && (!m_valid || commit_en);
    com = m_valid && commit_en;
    m_rv = com;
    if (com) begin
      m_pc = m_npc;
      m_instret = m_instret + 1;
      m_rnum = m_num;
      if (writes(m_inst)) begin
        if (int'(m_inst[11:7]) % 16 != 0) m_rf_a[int'(m_inst[11:7]) % 16] = m_wdata;
        if (m_inst[11:7] != 0) m_rf_b[m_inst[11:7]] = m_wdata;
      end
    end
    if (acc) begin
      m_valid = 1; m_inst = in_inst; m_wdata = in_wdata; m_npc = in_next_pc; m_num = in_num;
    end else if (com) begin
      m_valid = 0;
    end
  endtask

  task automatic check_all();
    logic exp_rdy;
    exp_rdy = !m_valid || commit_en;
    chk("ready_a", rdy_a, exp_rdy);
    chk("ready_b", rdy_b, exp_rdy);
    chk("pc_a", pc_a, m_pc);            chk("pc_b", pc_b, m_pc);
    chk("instret_a", ir_a, m_instret);  chk("instret_b", ir_b, m_instret);
    chk("retire_valid_a", rv_a, m_rv);  chk("retire_valid_b", rv_b, m_rv);
    chk("retire_num_a", rnum_a, m_rnum); chk("retire_num_b", rnum_b, m_rnum);
    chk("hz_valid_a", hzv_a, m_valid);  chk("hz_valid_b", hzv_b, m_valid);
    chk("hz_inst_a", hzi_a, m_inst);    chk("hz_data_a", hzd_a, m_wdata);
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("rdata_a[%0d] x%0d", p, raddr[p*5 +: 5]), rdata_a[p*32 +: 32], m_read(0, raddr[p*5 +: 5]));
      chk($sformatf("rdata_b[%0d] x%0d", p, raddr[p*5 +: 5]), rdata_b[p*32 +: 32], m_read(1, raddr[p*5 +: 5]));
    end
  endtask

  // Called #1 after a falling edge with inputs already driven.
  task automatic do_cycle();
    check_all();
    model_edge();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [6:0] op,
                       input logic [31:0] wd, input logic [31:0] npc, input logic [63:0] num,
                       input logic cen, input logic [4:0] ra);
    in_valid = v; in_inst = {20'h0, rd, op}; in_wdata = wd; in_next_pc = npc;
    in_num = num; commit_en = cen; raddr = {ra + 5'd1, ra};
  endtask

  typedef struct {
    logic v; logic [4:0] rd; logic [6:0] op; logic [31:0] wd; logic [31:0] npc;
    logic [63:0] num; logic cen; logic [4:0] ra;
    logic e_rdy; logic [31:0] e_rd0; logic e_rv; logic [63:0] e_ir; logic [31:0] e_pc;
  } vec_t;

  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1'b1, 5'd1,  OP_ADDI, 32'h11, P+4,    64'd1,  1'b1, 5'd1,  1'b1, 32'h0,        1'b0, 64'd0, P};
    tbl[1]  = '{1'b1, 5'd2,  OP_ADDI, 32'h22, P+8,    64'd2,  1'b1, 5'd1,  1'b1, 32'h11,       1'b0, 64'd0, P};
    tbl[2]  = '{1'b1, 5'd3,  OP_ADDI, 32'h33, P+12,   64'd3,  1'b1, 5'd2,  1'b1, 32'h22,       1'b1, 64'd1, P+4};
    tbl[3]  = '{1'b1, 5'd5,  OP_LW,   32'hDEAD_BEEF, P+16, 64'd4, 1'b1, 5'd3, 1'b1, 32'h33,    1'b1, 64'd2, P+8};
    tbl[4]  = '{1'b0, 5'd0,  OP_ADDI, 32'h0,  32'h0,  64'd0,  1'b0, 5'd5,  1'b0, 32'hDEAD_BEEF, 1'b1, 64'd3, P+12};
    tbl[5]  = '{1'b0, 5'd0,  OP_ADDI, 32'h0,  32'h0,  64'd0,  1'b0, 5'd5,  1'b0, 32'hDEAD_BEEF, 1'b0, 64'd3, P+12};
    tbl[6]  = '{1'b1, 5'd9,  OP_ADDI, 32'h99, P+64,   64'd99, 1'b0, 5'd5,  1'b0, 32'hDEAD_BEEF, 1'b0, 64'd3, P+12};
    tbl[7]  = '{1'b0, 5'd0,  OP_ADDI, 32'h0,  32'h0,  64'd0,  1'b1, 5'd5,  1'b1, 32'hDEAD_BEEF, 1'b0, 64'd3, P+12};
    tbl[8]  = '{1'b1, 5'd0,  OP_ADDI, 32'h77, P+20,   64'd5,  1'b1, 5'd5,  1'b1, 32'hDEAD_BEEF, 1'b1, 64'd4, P+16};
    tbl[9]  = '{1'b1, 5'd16, OP_ADDI, 32'h66, P+24,   64'd6,  1'b1, 5'd0,  1'b1, 32'h0,        1'b0, 64'd4, P+16};
    tbl[10] = '{1'b1, 5'd7,  OP_SW,   32'h55, P+16,   64'd7,  1'b1, 5'd16, 1'b1, 32'h0,        1'b1, 64'd5, P+20};
    tbl[11] = '{1'b0, 5'd0,  OP_ADDI, 32'h0,  32'h0,  64'd0,  1'b1, 5'd7,  1'b1, 32'h0,        1'b1, 64'd6, P+24};
    tbl[12] = '{1'b0, 5'd0,  OP_ADDI, 32'h0,  32'h0,  64'd0,  1'b1, 5'd7,  1'b1, 32'h0,        1'b1, 64'd7, P+16};
    tbl[13] = '{1'b0, 5'd0,  OP_ADDI, 32'h0,  32'h0,  64'd0,  1'b1, 5'd16, 1'b1, 32'h0,        1'b0, 64'd7, P+16};

    model_reset();
    repeat (3) @(negedge clock);
    reset = 1'b1;

    for (int r = 0; r < 14; r++) begin
      drive(tbl[r].v, tbl[r].rd, tbl[r].op, tbl[r].wd, tbl[r].npc, tbl[r].num, tbl[r].cen, tbl[r].ra);
      #1;
      chk($sformatf("vec%0d in_ready", r), rdy_a, tbl[r].e_rdy);
      chk($sformatf("vec%0d rdata0", r), rdata_a[31:0], tbl[r].e_rd0);
      chk($sformatf("vec%0d retire_valid", r), rv_a, tbl[r].e_rv);
      chk($sformatf("vec%0d instret", r), ir_a, tbl[r].e_ir);
      chk($sformatf("vec%0d pc", r), pc_a, tbl[r].e_pc);
      do_cycle();
    end

    // Sweep every address through both read ports against the model.
    for (int a = 0; a < 32; a += 2) begin
      drive(1'b0, 5'd0, OP_ADDI, 32'h0, 32'h0, 64'd0, 1'b0, 5'(a));
      #1;
      do_cycle();
    end
    drive(1'b0, 5'd0, OP_ADDI, 32'h0, 32'h0, 64'd0, 1'b0, 5'd16);
    #1;
    chk("x16 dropped with 16 regs", rdata_a[31:0], 32'h0);
    chk("x16 written with 32 regs", rdata_b[31:0], 32'h66);

    // Reset while the slot is full and stalled: discarded, never retired.
    @(negedge clock);
    drive(1'b1, 5'd4, OP_ADDI, 32'hABCD, P+128, 64'd500, 1'b1, 5'd1);
    #1;
    do_cycle();
    drive(1'b0, 5'd0, OP_ADDI, 32'h0, 32'h0, 64'd0, 1'b0, 5'd1);
    #1;
    do_cycle();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async reset hz_valid", hzv_a, 1'b0);
    chk("async reset pc", pc_a, P);
    chk("async reset instret", ir_a, 64'd0);
    chk("async reset retire_valid", rv_a, 1'b0);
    chk("async reset rf x1", rdata_a[31:0], 32'h0);
    @(negedge clock);
    reset = 1'b1;
    commit_en = 1'b1;
    #1;
    do_cycle();
    chk("no retire after reset", rv_a, 1'b0);

    // Randomised traffic against the model.
    for (int c = 0; c < 400; c++) begin
      logic [6:0] op;
      logic [4:0] ra0, ra1;
      op = ($urandom_range(0, 4) == 0) ? (($urandom & 1) != 0 ? OP_SW : 7'b1100011)
                                        : wen_ops[$urandom_range(0, 7)];
      ra0 = 5'($urandom); ra1 = 5'($urandom);
      in_valid   = ($urandom_range(0, 3) != 0);
      in_inst    = {$urandom} & 32'hFFFF_FF80 | {25'h0, op};
      in_wdata   = $urandom;
      in_next_pc = $urandom;
      in_num     = {$urandom, $urandom};
      commit_en  = ($urandom_range(0, 3) != 0);
      raddr      = {ra1, ra0};
      #1;
      do_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
